// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
// Module   : collision_detector
// Purpose  : Evaluates each proposed snake head position. It checks the head
//            against the playfield walls, then compares it against the stored
//            body one segment per cycle, and finally checks it against the
//            apple. A successful move shifts the body. An apple hit also grows
//            the body, up to MAX_LEN segments.
// Ports    : clk            - system clock, all state on rising edge
//            rst            - asynchronous active-high reset
//            move           - one-cycle strobe, headX/headY valid that cycle
//            headX, headY   - proposed new head coordinates
//            appleX, appleY - apple coordinates, sampled on the last compare
//            goodColl       - one-cycle pulse, head landed on apple
//            badColl        - one-cycle pulse, wall or self collision
//            busy           - high while a move is being scanned
//            gameOver       - high after any bad collision, until reset
//            len            - current body length (segments excluding head)
// Revision : 1.0 - initial release
// ============================================================================
module collision_detector #(
  parameter int GRID    = 10,
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move,
  input  logic [3:0] headX,
  input  logic [3:0] headY,
  input  logic [3:0] appleX,
  input  logic [3:0] appleY,
  output logic       goodColl,
  output logic       badColl,
  output logic       busy,
  output logic       gameOver,
  output logic [4:0] len
);

  localparam int         c_IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [4:0] c_GRID    = 5'(GRID);
  localparam logic [4:0] c_MAX_LEN = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cand_x_q, cand_x_d;
  logic [3:0] cand_y_q, cand_y_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] len_q, len_d;
  logic       good_q, good_d;
  logic       bad_q, bad_d;
  logic [3:0] head_x_q, head_y_q;
  logic [3:0] body_x_q [MAX_LEN];
  logic [3:0] body_y_q [MAX_LEN];

  logic            commit;     // move accepted: shift body, head <= candidate
  logic            oob;        // incoming head is outside the playfield
  logic            hit;        // candidate equals the body segment at idx_q
  logic            last_cmp;   // current compare is the final body segment
  logic            apple_hit;
  logic [c_IW-1:0] idx_sel;

  assign idx_sel   = idx_q[c_IW-1:0];
  assign oob       = ({1'b0, headX} >= c_GRID) || ({1'b0, headY} >= c_GRID);
  assign hit       = (body_x_q[idx_sel] == cand_x_q) && (body_y_q[idx_sel] == cand_y_q);
  assign last_cmp  = (idx_q == (len_q - 5'd1));
  assign apple_hit = (cand_x_q == appleX) && (cand_y_q == appleY);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    idx_d    = idx_q;
    len_d    = len_q;
    good_d   = 1'b0;
    bad_d    = 1'b0;
    commit   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (move) begin
          cand_x_d = headX;
          cand_y_d = headY;
          idx_d    = 5'd0;
          // A wall hit takes priority over an apple on the same cell.
          if (oob) begin
            bad_d   = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        if (hit) begin
          bad_d   = 1'b1;
          state_d = S_OVER;
        end else if (last_cmp) begin
          commit  = 1'b1;
          state_d = S_IDLE;
          if (apple_hit) begin
            good_d = 1'b1;
            // At saturation the shift drops the tail, so the length holds.
            if (len_q < c_MAX_LEN) begin
              len_d = len_q + 5'd1;
            end
          end
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cand_x_q <= 4'd0;
      cand_y_q <= 4'd0;
      idx_q    <= 5'd0;
      len_q    <= 5'd2;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  // --------------------------------------------------------------------------
  // Head and body storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_x_q <= 4'd5;
      head_y_q <= 4'd5;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x_q[i] <= (i == 0) ? 4'd4 : ((i == 1) ? 4'd3 : 4'd0);
        body_y_q[i] <= (i < 2) ? 4'd5 : 4'd0;
      end
    end else if (commit) begin
      head_x_q    <= cand_x_q;
      head_y_q    <= cand_y_q;
      body_x_q[0] <= head_x_q;
      body_y_q[0] <= head_y_q;
      for (int i = 1; i < MAX_LEN; i++) begin
        body_x_q[i] <= body_x_q[i-1];
        body_y_q[i] <= body_y_q[i-1];
      end
    end
  end

  assign goodColl = good_q;
  assign badColl  = bad_q;
  assign busy     = (state_q == S_SCAN);
  assign gameOver = (state_q == S_OVER);
  assign len      = len_q;

endmodule
`default_nettype wire
